// File: rtl/snoop_dispatcher.sv
// ---------------------------------------------------------------------------
// snoop_dispatcher
//
// Takes one snoop-filter result at a time and fans it out as per-RN snoop
// requests. It then collects the snoop responses and reports a single
// completion that carries the tag, the requester NodeID, a merged dirty flag
// and a timeout flag.
//
// Parameters
//   WIDTH    snoop tag width
//   TIMEOUT  maximum number of WAIT cycles before a forced completion (1..255)
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   req_valid/req_ready        filter result handshake
//   req_tag/opcode/nid/flag    filter result payload (flag bit j -> RN(j+1))
//   snp_valid/snp_ready [3:0]  per-RN snoop request handshake
//   snp_tag, snp_op            shared snoop payload
//   snp_resp_valid/dirty [3:0] per-RN snoop response pulses
//   done_valid/done_ready      completion handshake
//   done_tag/nid/dirty/timeout completion payload
//   busy                       high whenever a transaction is in flight
//
// While reset is high every output is held at 0. req_ready therefore rises
// in the first cycle after reset is released.
// ---------------------------------------------------------------------------
module snoop_dispatcher #(
    parameter int WIDTH   = 33,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_tag,
    input  logic [6:0]       req_opcode,
    input  logic [6:0]       req_nid,
    input  logic [3:0]       req_flag,
    output logic [3:0]       snp_valid,
    input  logic [3:0]       snp_ready,
    output logic [WIDTH-1:0] snp_tag,
    output logic [1:0]       snp_op,
    input  logic [3:0]       snp_resp_valid,
    input  logic [3:0]       snp_resp_dirty,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] done_tag,
    output logic [6:0]       done_nid,
    output logic             done_dirty,
    output logic             done_timeout,
    output logic             busy
);

    localparam logic [6:0] OP_READ_SHARED = 7'h01;
    localparam logic [6:0] OP_READ_UNIQUE = 7'h07;
    localparam logic [7:0] TIMEOUT_C      = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_reg,   state_next;
    logic [WIDTH-1:0]   tag_reg,     tag_next;
    logic [6:0]         nid_reg,     nid_next;
    logic [1:0]         op_reg,      op_next;
    logic [3:0]         pend_reg,    pend_next;
    logic [3:0]         sent_reg,    sent_next;
    logic               dirty_reg,   dirty_next;
    logic               timeout_reg, timeout_next;
    logic [7:0]         cnt_reg,     cnt_next;

    // Per-RN event vectors for the current cycle
    logic [3:0] hs;          // snoop request handshake
    logic [3:0] resp_acc;    // response accepted (snoop was outstanding)
    logic [3:0] resp_dirty;  // accepted response reported dirty
    logic [3:0] pend_upd;    // pend after this cycle's handshakes
    logic [3:0] sent_upd;    // sent after this cycle's handshakes/responses
    logic       collecting;  // responses are meaningful only in ISSUE/WAIT
    logic [7:0] cnt_inc;
    logic [1:0] op_map;

    assign collecting = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
    assign cnt_inc    = cnt_reg + 8'd1;

    // Each RN is handled independently, so several snoops may hand off and
    // several responses may land in the same cycle. A response counts only
    // if its snoop had already been handed off by the start of the cycle.
    // A response in the same cycle as the handshake is ignored.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rn
            assign hs[gi]         = (state_reg == ST_ISSUE) & pend_reg[gi] & snp_ready[gi];
            assign resp_acc[gi]   = collecting & sent_reg[gi] & snp_resp_valid[gi];
            assign resp_dirty[gi] = resp_acc[gi] & snp_resp_dirty[gi];
            assign pend_upd[gi]   = pend_reg[gi] & ~hs[gi];
            assign sent_upd[gi]   = (sent_reg[gi] & ~resp_acc[gi]) | hs[gi];
        end
    endgenerate

    // The opcode is reduced to the snoop type once, at acceptance
    always_comb begin
        op_map = 2'b00;
        if (req_opcode == OP_READ_SHARED) begin
            op_map = 2'b01;
        end else if (req_opcode == OP_READ_UNIQUE) begin
            op_map = 2'b10;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tag_next     = tag_reg;
        nid_next     = nid_reg;
        op_next      = op_reg;
        pend_next    = pend_reg;
        sent_next    = sent_reg;
        dirty_next   = dirty_reg;
        timeout_next = timeout_reg;
        cnt_next     = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    tag_next     = req_tag;
                    nid_next     = req_nid;
                    op_next      = op_map;
                    pend_next    = req_flag;
                    sent_next    = 4'b0000;
                    dirty_next   = 1'b0;
                    timeout_next = 1'b0;
                    cnt_next     = 8'd0;
                    // An empty snoop vector completes immediately
                    state_next   = (req_flag == 4'b0000) ? ST_DONE : ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                pend_next  = pend_upd;
                sent_next  = sent_upd;
                dirty_next = dirty_reg | (|resp_dirty);
                if (pend_upd == 4'b0000) begin
                    cnt_next   = 8'd0;
                    state_next = (sent_upd == 4'b0000) ? ST_DONE : ST_WAIT;
                end
            end

            ST_WAIT: begin
                sent_next  = sent_upd;
                dirty_next = dirty_reg | (|resp_dirty);
                cnt_next   = cnt_inc;
                if (sent_upd == 4'b0000) begin
                    state_next = ST_DONE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    // Give up on the missing responses. Any response that
                    // arrives later finds sent clear and is dropped.
                    state_next   = ST_DONE;
                    timeout_next = 1'b1;
                    sent_next    = 4'b0000;
                end
            end

            ST_DONE: begin
                if (done_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            tag_reg     <= '0;
            nid_reg     <= 7'd0;
            op_reg      <= 2'b00;
            pend_reg    <= 4'b0000;
            sent_reg    <= 4'b0000;
            dirty_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            cnt_reg     <= 8'd0;
        end else begin
            state_reg   <= state_next;
            tag_reg     <= tag_next;
            nid_reg     <= nid_next;
            op_reg      <= op_next;
            pend_reg    <= pend_next;
            sent_reg    <= sent_next;
            dirty_reg   <= dirty_next;
            timeout_reg <= timeout_next;
            cnt_reg     <= cnt_next;
        end
    end

    // Outputs come straight from registered state, gated by reset. This
    // keeps every output at 0 while reset is high, before the first edge.
    always_comb begin
        req_ready    = 1'b0;
        snp_valid    = 4'b0000;
        snp_tag      = '0;
        snp_op       = 2'b00;
        done_valid   = 1'b0;
        done_tag     = '0;
        done_nid     = 7'd0;
        done_dirty   = 1'b0;
        done_timeout = 1'b0;
        busy         = 1'b0;
        if (!reset) begin
            req_ready    = (state_reg == ST_IDLE);
            snp_valid    = (state_reg == ST_ISSUE) ? pend_reg : 4'b0000;
            snp_tag      = tag_reg;
            snp_op       = op_reg;
            done_valid   = (state_reg == ST_DONE);
            done_tag     = tag_reg;
            done_nid     = nid_reg;
            done_dirty   = dirty_reg;
            done_timeout = timeout_reg;
            busy         = (state_reg != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_snoop_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_snoop_dispatcher
//
// Drives filter results with per-RN snoop-ready delays, response delays and
// dirty bits. Completion timing and payload are predicted from transaction
// level rules:
//   * snoop j is valid from the first ISSUE cycle through its ready cycle h_j
//   * H = last handshake cycle; a response at cycle h_j+r_j counts if r_j>=1
//     and h_j+r_j <= H+TIMEOUT
//   * completion appears at (last counted response + 1), or at H+TIMEOUT+1
//     with the timeout flag when some response is missing
// ---------------------------------------------------------------------------
module tb_snoop_dispatcher;

    localparam int W  = 33;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_tag;
    logic [6:0]   req_opcode;
    logic [6:0]   req_nid;
    logic [3:0]   req_flag;
    logic [3:0]   snp_valid;
    logic [3:0]   snp_ready;
    logic [W-1:0] snp_tag;
    logic [1:0]   snp_op;
    logic [3:0]   snp_resp_valid;
    logic [3:0]   snp_resp_dirty;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] done_tag;
    logic [6:0]   done_nid;
    logic         done_dirty;
    logic         done_timeout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    // Per-RN scenario: ready cycle, response delay (0 = never), dirty bit,
    // and a stray response cycle (-1 = none) that must be ignored
    int t_h  [4];
    int t_r  [4];
    int t_sp [4];
    bit t_d  [4];

    snoop_dispatcher #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_tag        (req_tag),
        .req_opcode     (req_opcode),
        .req_nid        (req_nid),
        .req_flag       (req_flag),
        .snp_valid      (snp_valid),
        .snp_ready      (snp_ready),
        .snp_tag        (snp_tag),
        .snp_op         (snp_op),
        .snp_resp_valid (snp_resp_valid),
        .snp_resp_dirty (snp_resp_dirty),
        .done_valid     (done_valid),
        .done_ready     (done_ready),
        .done_tag       (done_tag),
        .done_nid       (done_nid),
        .done_dirty     (done_dirty),
        .done_timeout   (done_timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_op(input logic [6:0] op);
        if (op == 7'h01) return 2'b01;
        if (op == 7'h07) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_scn();
        for (int j = 0; j < 4; j++) begin
            t_h[j] = 0; t_r[j] = 1; t_sp[j] = -1; t_d[j] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        req_valid      = 1'b0;
        req_tag        = '0;
        req_opcode     = 7'd0;
        req_nid        = 7'd0;
        req_flag       = 4'd0;
        snp_ready      = 4'd0;
        snp_resp_valid = 4'd0;
        snp_resp_dirty = 4'd0;
        done_ready     = 1'b0;
    endtask

    // One full transaction: entered and left at posedge+#1
    task automatic run_txn(input logic [W-1:0] tag, input logic [6:0] op,
                           input logic [6:0] nid, input logic [3:0] flag,
                           input int stall, input string name);
        int  hmax, lmax, dcyc, c;
        bit  to, dty;
        logic [3:0] ev, rv, rd;

        // Reference prediction
        hmax = 0; lmax = -1; to = 1'b0; dty = 1'b0;
        for (int j = 0; j < 4; j++)
            if (flag[j] && t_h[j] > hmax) hmax = t_h[j];
        if (flag == 4'd0) begin
            dcyc = 0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (flag[j]) begin
                    if (t_r[j] > 0 && t_h[j] + t_r[j] <= hmax + TO) begin
                        if (t_h[j] + t_r[j] > lmax) lmax = t_h[j] + t_r[j];
                        dty = dty | t_d[j];
                    end else begin
                        to = 1'b1;
                    end
                end
            end
            dcyc = to ? hmax + TO + 1 : lmax + 1;
        end

        // Acceptance cycle
        req_valid = 1'b1; req_tag = tag; req_opcode = op; req_nid = nid; req_flag = flag;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: req_ready=%b busy=%b required req_ready=1 busy=0", name, req_ready, busy);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_flag  = 4'($urandom_range(0, 15));

        for (c = 0; c <= dcyc + stall && c < 300; c++) begin
            rv = 4'd0; rd = 4'd0;
            for (int j = 0; j < 4; j++) begin
                snp_ready[j] = flag[j] ? (c >= t_h[j]) : 1'($urandom_range(0, 1));
                if (flag[j] && t_r[j] > 0 && c == t_h[j] + t_r[j]) begin
                    rv[j] = 1'b1; rd[j] = t_d[j];
                end else if (c == t_sp[j]) begin
                    rv[j] = 1'b1; rd[j] = 1'b1;
                end
            end
            snp_resp_valid = rv;
            snp_resp_dirty = rd;
            done_ready     = (c >= dcyc + stall);

            @(negedge clk);
            for (int j = 0; j < 4; j++) ev[j] = flag[j] && (c <= t_h[j]);
            checks++;
            if (snp_valid !== ev) begin
                failures++;
                $display("FAIL %s snp_valid c=%0d: got %b required %b", name, c, snp_valid, ev);
            end
            if (ev != 4'd0) begin
                checks++;
                if (snp_op !== exp_op(op) || snp_tag !== tag) begin
                    failures++;
                    $display("FAIL %s snp_payload c=%0d: op=%b tag=%h required op=%b tag=%h",
                             name, c, snp_op, snp_tag, exp_op(op), tag);
                end
            end
            checks++;
            if (done_valid !== (c >= dcyc) || busy !== 1'b1 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s done_valid c=%0d: done_valid=%b busy=%b req_ready=%b required done_valid=%b busy=1 req_ready=0",
                         name, c, done_valid, busy, req_ready, (c >= dcyc));
            end
            if (c >= dcyc) begin
                checks++;
                if (done_tag !== tag || done_nid !== nid || done_dirty !== dty || done_timeout !== to) begin
                    failures++;
                    $display("FAIL %s done_payload c=%0d: tag=%h nid=%h dirty=%b timeout=%b required tag=%h nid=%h dirty=%b timeout=%b",
                             name, c, done_tag, done_nid, done_dirty, done_timeout, tag, nid, dty, to);
                end
            end
            @(posedge clk); #1;
        end
        if (c >= 300) begin
            failures++;
            $display("FAIL %s bound: cycle budget exhausted", name);
        end
        snp_ready = 4'd0; snp_resp_valid = 4'd0; snp_resp_dirty = 4'd0; done_ready = 1'b0;
        $display("txn %s flag=%b op=%h done_cycle=%0d dirty=%b timeout=%b stall=%0d",
                 name, flag, op, dcyc, dty, to, stall);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset     = 1'b1;
        req_valid = 1'b1;
        req_flag  = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || snp_valid !== 4'd0 || done_valid !== 1'b0 || busy !== 1'b0 ||
            snp_tag !== '0 || snp_op !== 2'b00 || done_tag !== '0 || done_nid !== 7'd0 ||
            done_dirty !== 1'b0 || done_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: req_ready=%b snp_valid=%b done_valid=%b busy=%b required all 0",
                     req_ready, snp_valid, done_valid, busy);
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: req_ready=%b busy=%b done_valid=%b required 1 0 0",
                     req_ready, busy, done_valid);
        end
        @(posedge clk); #1;
        $display("txn reset checked");
    endtask

    task automatic test_no_snoop();
        clear_scn();
        run_txn(33'h1_2345_6789, 7'h1B, 7'h04, 4'b0000, 0, "no_snoop");
    endtask

    task automatic test_fanout_dirty();
        clear_scn();
        t_h[1] = 0; t_r[1] = 2; t_d[1] = 1'b0;
        t_h[2] = 0; t_r[2] = 1; t_d[2] = 1'b1;
        t_h[3] = 0; t_r[3] = 3; t_d[3] = 1'b0;
        run_txn(33'h0_DEAD_BEEF, 7'h07, 7'h01, 4'b1110, 1, "fanout_dirty");
    endtask

    task automatic test_delayed_ready();
        clear_scn();
        t_h[0] = 3; t_r[0] = 2; t_d[0] = 1'b0;
        t_h[2] = 0; t_r[2] = 1; t_d[2] = 1'b0;
        run_txn(33'h1_0000_0001, 7'h01, 7'h10, 4'b0101, 0, "delayed_ready");
    endtask

    task automatic test_ignored_resp();
        clear_scn();
        t_h[0] = 1; t_r[0] = 2; t_d[0] = 1'b0;
        t_sp[1] = 0;
        t_sp[2] = 3;
        run_txn(33'h0_5555_AAAA, 7'h01, 7'h02, 4'b0001, 0, "ignored_unflagged");
        clear_scn();
        t_h[0] = 0; t_r[0] = 1; t_d[0] = 1'b0;
        t_h[1] = 3; t_r[1] = 2; t_d[1] = 1'b0;
        t_sp[1] = 1;
        run_txn(33'h1_AAAA_5555, 7'h07, 7'h08, 4'b0011, 0, "ignored_before_handshake");
    endtask

    task automatic test_timeout();
        clear_scn();
        t_h[1] = 1; t_r[1] = 0;
        run_txn(33'h0_0F0F_0F0F, 7'h07, 7'h20, 4'b0010, 2, "timeout");
        clear_scn();
        t_h[0] = 0; t_r[0] = 1; t_d[0] = 1'b1;
        t_h[3] = 0; t_r[3] = TO + 1;
        run_txn(33'h1_F0F0_F0F0, 7'h01, 7'h40, 4'b1001, 0, "timeout_late_resp");
    endtask

    task automatic test_reset_in_wait();
        int bad;
        req_valid = 1'b1; req_tag = 33'h1_1111_1111; req_opcode = 7'h07;
        req_nid = 7'h01; req_flag = 4'b0001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        snp_ready = 4'b0001;
        @(posedge clk); #1;
        snp_ready = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || snp_valid !== 4'd0 || done_valid !== 1'b0 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL wait_reset_outputs: busy=%b snp_valid=%b done_valid=%b req_ready=%b required all 0",
                     busy, snp_valid, done_valid, req_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        snp_resp_valid = 4'b0001; snp_resp_dirty = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_reset_release: req_ready=%b busy=%b required 1 0", req_ready, busy);
        end
        @(posedge clk); #1;
        snp_resp_valid = 4'd0; snp_resp_dirty = 4'd0;
        bad = 0;
        for (int k = 0; k < TO + 3; k++) begin
            @(negedge clk);
            if (done_valid !== 1'b0 || busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wait_reset_abandon: %0d cycles with done_valid/busy high, required 0", bad);
        end
        $display("txn reset_in_wait checked");
        clear_scn();
        t_h[0] = 0; t_r[0] = 2; t_d[0] = 1'b0;
        run_txn(33'h0_2222_2222, 7'h01, 7'h02, 4'b0001, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [63:0] rnd;
        logic [6:0]  op;
        logic [3:0]  flag;
        for (int n = 0; n < 40; n++) begin
            clear_scn();
            flag = 4'($urandom_range(0, 15));
            for (int j = 0; j < 4; j++) begin
                t_h[j] = $urandom_range(0, 3);
                t_r[j] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
                t_d[j] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) t_sp[j] = flag[j] ? $urandom_range(0, t_h[j]) : $urandom_range(0, 6);
            end
            case ($urandom_range(0, 3))
                0: op = 7'h01;
                1: op = 7'h07;
                2: op = 7'h1B;
                default: op = 7'($urandom_range(0, 127));
            endcase
            rnd = {$urandom, $urandom};
            run_txn(rnd[W-1:0], op, 7'(1 << $urandom_range(0, 6)), flag,
                    $urandom_range(0, 2), $sformatf("random%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_no_snoop();
        test_fanout_dirty();
        test_delayed_ready();
        test_ignored_resp();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snoop_dispatcher.md
SNOOP_DISPATCHER -- requirements
Module: snoop_dispatcher

Interface
REQ-001 SHALL have parameter WIDTH, default 33, the snoop tag width.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum WAIT cycles before forced completion (1..255).
REQ-003 SHALL have port clk  input  1  the system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  a filter result is offered.
REQ-006 SHALL have port req_ready  output  1  the dispatcher accepts the filter result.
REQ-007 SHALL have port req_tag  input  WIDTH  the filtered line tag.
REQ-008 SHALL have port req_opcode  input  7  the requester opcode (ReadShared 7'h01, ReadUnique 7'h07, WriteBackFull 7'h1B).
REQ-009 SHALL have port req_nid  input  7  the requester one-hot NodeID.
REQ-010 SHALL have port req_flag  input  4  the filter snoop vector; bit j set means snoop RN(j+1).
REQ-011 SHALL have port snp_valid  output  4  a per-RN snoop request is valid.
REQ-012 SHALL have port snp_ready  input  4  a per-RN snoop request is accepted.
REQ-013 SHALL have port snp_tag  output  WIDTH  the shared snoop tag.
REQ-014 SHALL have port snp_op  output  2  the snoop type: 01 SnpShared, 10 SnpUnique, 00 SnpClean.
REQ-015 SHALL have port snp_resp_valid  input  4  a per-RN snoop response, single-cycle pulse.
REQ-016 SHALL have port snp_resp_dirty  input  4  a per-RN dirty indication, qualified by snp_resp_valid.
REQ-017 SHALL have port done_valid  output  1  the transaction completion is valid.
REQ-018 SHALL have port done_ready  input  1  the consumer accepts the completion.
REQ-019 SHALL have ports done_tag (WIDTH), done_nid (7), done_dirty (1) and done_timeout (1), all outputs, carrying the completion payload.
REQ-020 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE, with one transaction in flight.
REQ-022 SHALL drive req_ready=1 only in IDLE; on req_valid&req_ready, the FSM SHALL latch tag, nid, flag into pend[3:0], set sent[3:0]=0 and dirty=0.
REQ-023 SHALL, on acceptance with req_flag==0, go to DONE on the next cycle with no snoop issued.
REQ-024 SHALL, on acceptance with req_flag!=0, go to ISSUE.
REQ-025 SHALL, in ISSUE, drive snp_valid=pend; on snp_valid[j]&snp_ready[j] it SHALL clear pend[j] and set sent[j]; snp_valid[j] SHALL NOT deassert before its handshake.
REQ-026 SHALL issue snoops independently and in any order across RNs; several handshakes in one cycle are legal.
REQ-027 SHALL map snp_op from the latched opcode: ReadShared->01, ReadUnique->10, any other->00; snp_tag SHALL equal the latched tag.
REQ-028 SHALL accept snp_resp_valid[j] only when sent[j] was set at the start of the cycle; it SHALL then clear sent[j] and OR snp_resp_dirty[j] into dirty. Responses with sent[j]=0 SHALL be ignored. Responses are legal in ISSUE.
REQ-029 SHALL go from ISSUE to WAIT when pend becomes 0, or directly to DONE if sent is also 0 after that cycle's updates.
REQ-030 SHALL go from WAIT to DONE when sent becomes 0.
REQ-031 SHALL, in WAIT, run an 8-bit counter cleared on entry and incremented each cycle; when it reaches TIMEOUT with sent!=0, it SHALL go to DONE with done_timeout=1 and clear sent.
REQ-032 SHALL, in DONE, hold done_valid=1 and a stable payload until done_ready; on handshake it SHALL return to IDLE, and req_ready SHALL rise the next cycle.
REQ-033 SHALL make done_dirty the OR of all accepted dirty responses; done_timeout SHALL be 0 unless set by REQ-031.

Reset
REQ-034 SHALL, while reset=1, force IDLE, pend=sent=0, the counter to 0 and dirty=0; all outputs SHALL be 0 except req_ready, which SHALL be 0 during reset and 1 in the first cycle after.
REQ-035 SHALL, on reset asserted mid-transaction, abandon the transaction with no done_valid pulse; responses arriving later SHALL be ignored.

Verification
REQ-036 SHALL be verified with flag=4'b0000, opcode WriteBackFull -> no snp_valid, done_valid 1 cycle after acceptance, dirty=0, timeout=0.
REQ-037 SHALL be verified with flag=4'b1110, ReadUnique, snp_ready all 1 -> snp_valid=1110 for one cycle, snp_op=10; responses from RN2/RN3/RN4 with RN3 dirty -> done_dirty=1.
REQ-038 SHALL be verified with flag=4'b0101, snp_ready[0] delayed 3 cycles -> snp_valid[0] held 4 cycles, snp_valid[2] dropped after its handshake; done only after both responses.
REQ-039 SHALL be verified with a response on RN2 while sent[1]=0 -> ignored, no state change.
REQ-040 SHALL be verified with flag=4'b0010, TIMEOUT=4, no response -> done_valid after 4 WAIT cycles with done_timeout=1.
REQ-041 SHALL be verified with reset pulsed in WAIT -> IDLE, no done_valid, req_ready=1 the cycle after reset deasserts.
